// File: rtl/io_timer_defs_pkg.sv
// Shared IO timer constants: register word indices, CTRL/STATUS bit positions, default region.
// Pure definitions, no logic; the responder and software headers both mirror these values.
package io_timer_defs_pkg;
    localparam logic [10:0] IO_BASE_DEF = 11'h010;

    localparam logic [2:0] W_MTIME_LO = 3'd0;
    localparam logic [2:0] W_MTIME_HI = 3'd1;
    localparam logic [2:0] W_CMP_LO   = 3'd2;
    localparam logic [2:0] W_CMP_HI   = 3'd3;
    localparam logic [2:0] W_CTRL     = 3'd4;
    localparam logic [2:0] W_PRESCALE = 3'd5;
    localparam logic [2:0] W_STATUS   = 3'd6;
    localparam logic [2:0] W_RSVD     = 3'd7;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_PEND   = 0;
    localparam int STAT_WRAP   = 1;
endpackage

// File: rtl/io_timer_prescaler.sv
// Timer prescaler: o_inc is combinational on the increment cycle, o_tick follows it one cycle later.
// No backpressure; i_clr restarts the count from zero.
module io_timer_prescaler #(
    parameter int PS_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic [PS_WIDTH-1:0] i_prescale,
    output logic                o_inc,
    output logic                o_tick
);
    logic [PS_WIDTH-1:0] r_pc;
    logic                r_tick;

    assign o_inc  = i_en && (r_pc == i_prescale);
    assign o_tick = r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc   <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= o_inc;
            if (i_clr || o_inc) begin
                r_pc <= '0;
            end else if (i_en) begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end
endmodule

// File: rtl/io_timer_resp.sv
// Memory-mapped 64-bit machine timer; read data one cycle after request, 0 otherwise, writes take effect at once.
// Optional coherent MTIME_HI shadow under IO_TIMER_SHADOW_EN; no backpressure, always ready.
module io_timer_resp
    import io_timer_defs_pkg::*;
#(
    parameter logic [10:0] IO_BASE  = IO_BASE_DEF,
    parameter int          PS_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    output logic [31:0] dma_io_rdata,
    output logic        timer_irq,
    output logic        timer_tick
);
    logic [63:0]         r_mtime;
    logic [63:0]         r_cmp;
    logic [1:0]          r_ctrl;
    logic [PS_WIDTH-1:0] r_prescale;
    logic                r_pend;
    logic                r_wrap;
    logic [31:0]         r_rdata;

    logic        w_wr_hit;
    logic        w_rd_hit;
    logic [2:0]  w_widx;
    logic [2:0]  w_ridx;
    logic        w_wr_mt;
    logic        w_inc;
    logic        w_wrap;
    logic        w_w1c;
    logic        w_ps_clr;
    logic [31:0] w_ps_rd;
    logic [31:0] w_hi_rd;
    logic [31:0] w_rd_val;

    assign w_wr_hit = dma_io_we && (dma_io_wadr[13:3] == IO_BASE);
    assign w_rd_hit = dma_io_radr_en && (dma_io_radr[13:3] == IO_BASE);
    assign w_widx   = dma_io_wadr[2:0];
    assign w_ridx   = dma_io_radr[2:0];
    assign w_wr_mt  = w_wr_hit && ((w_widx == W_MTIME_LO) || (w_widx == W_MTIME_HI));
    assign w_ps_clr = w_wr_hit && ((w_widx == W_CTRL) || (w_widx == W_PRESCALE));
    assign w_w1c    = w_wr_hit && (w_widx == W_STATUS) && dma_io_wdata[STAT_WRAP];
    // A software write to mtime swallows the increment, so it cannot wrap either.
    assign w_wrap   = w_inc && !w_wr_mt && (r_mtime == 64'hFFFF_FFFF_FFFF_FFFF);

    io_timer_prescaler #(.PS_WIDTH(PS_WIDTH)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .i_en       (r_ctrl[CTRL_EN]),
        .i_clr      (w_ps_clr),
        .i_prescale (r_prescale),
        .o_inc      (w_inc),
        .o_tick     (timer_tick)
    );

`ifdef IO_TIMER_SHADOW_EN
    logic [31:0] r_shadow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (w_rd_hit && (w_ridx == W_MTIME_LO)) begin
            r_shadow <= r_mtime[63:32];
        end
    end

    assign w_hi_rd = r_shadow;
`else
    assign w_hi_rd = r_mtime[63:32];
`endif

    always_comb begin
        w_ps_rd                 = '0;
        w_ps_rd[PS_WIDTH-1:0]   = r_prescale;
    end

    always_comb begin
        w_rd_val = '0;
        case (w_ridx)
            W_MTIME_LO: w_rd_val = r_mtime[31:0];
            W_MTIME_HI: w_rd_val = w_hi_rd;
            W_CMP_LO:   w_rd_val = r_cmp[31:0];
            W_CMP_HI:   w_rd_val = r_cmp[63:32];
            W_CTRL:     w_rd_val = {30'd0, r_ctrl};
            W_PRESCALE: w_rd_val = w_ps_rd;
            W_STATUS:   w_rd_val = {30'd0, r_wrap, r_pend};
            default:    w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= '0;
            r_cmp      <= '0;
            r_ctrl     <= '0;
            r_prescale <= '0;
            r_pend     <= 1'b0;
            r_wrap     <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_pend  <= (r_mtime >= r_cmp);
            r_rdata <= w_rd_hit ? w_rd_val : 32'd0;

            if (w_wr_hit && (w_widx == W_MTIME_LO)) begin
                r_mtime[31:0] <= dma_io_wdata;
            end else if (w_wr_hit && (w_widx == W_MTIME_HI)) begin
                r_mtime[63:32] <= dma_io_wdata;
            end else if (w_inc) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr_hit && (w_widx == W_CMP_LO)) r_cmp[31:0]  <= dma_io_wdata;
            if (w_wr_hit && (w_widx == W_CMP_HI)) r_cmp[63:32] <= dma_io_wdata;
            if (w_wr_hit && (w_widx == W_CTRL))   r_ctrl       <= dma_io_wdata[1:0];
            if (w_wr_hit && (w_widx == W_PRESCALE)) begin
                r_prescale <= dma_io_wdata[PS_WIDTH-1:0];
            end

            if (w_wrap) begin
                r_wrap <= 1'b1;
            end else if (w_w1c) begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign dma_io_rdata = r_rdata;
    assign timer_irq    = r_pend && r_ctrl[CTRL_IRQ_EN];
endmodule

// File: tb/tb_io_timer_resp.sv
// Bench for io_timer_resp: register-map vector table, directed timer sequences, random traffic vs a reference model.
module tb_io_timer_resp;
    import io_timer_defs_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [13:0] wadr;
    logic [31:0] wdata;
    logic [13:0] radr;
    logic        ren;
    logic [31:0] rdata;
    logic        irq;
    logic        tick;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_timer_resp dut (
        .clk            (clk),
        .rst            (rst),
        .dma_io_we      (we),
        .dma_io_wadr    (wadr),
        .dma_io_wdata   (wdata),
        .dma_io_radr    (radr),
        .dma_io_radr_en (ren),
        .dma_io_rdata   (rdata),
        .timer_irq      (irq),
        .timer_tick     (tick)
    );

    // Reference model state: the timer as software sees it.
    longint unsigned m_mtime, m_cmp;
    int unsigned     m_ps, m_pc;
    bit [1:0]        m_ctrl;
    bit              m_pend, m_wrap, m_tick;
    logic [31:0]     m_rdata, m_shadow;

    function automatic logic [13:0] a(int unsigned idx);
        return {IO_BASE_DEF, 3'(idx)};
    endfunction

    function automatic logic [31:0] rdval(int unsigned i);
        case (i)
            0: return 32'(m_mtime);
`ifdef IO_TIMER_SHADOW_EN
            1: return m_shadow;
`else
            1: return 32'(m_mtime >> 32);
`endif
            2: return 32'(m_cmp);
            3: return 32'(m_cmp >> 32);
            4: return 32'(m_ctrl);
            5: return 32'(m_ps);
            6: return {30'd0, m_wrap, m_pend};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_step();
        bit whit, rhit, inc, wrapped;
        int unsigned widx, ridx;
        longint unsigned nm;
        if (rst) begin
            m_mtime = 0; m_cmp = 0; m_ps = 0; m_pc = 0; m_ctrl = 0;
            m_pend = 0; m_wrap = 0; m_tick = 0; m_rdata = 0; m_shadow = 0;
            return;
        end
        whit = we && (wadr[13:3] == IO_BASE_DEF);
        rhit = ren && (radr[13:3] == IO_BASE_DEF);
        widx = 32'(wadr[2:0]);
        ridx = 32'(radr[2:0]);
        m_rdata = rhit ? rdval(ridx) : 32'd0;
        if (rhit && ridx == 0) m_shadow = 32'(m_mtime >> 32);
        inc = m_ctrl[0] && (m_pc == m_ps);
        m_tick = inc;
        wrapped = 0;
        nm = m_mtime;
        if (whit && widx == 0)      nm = (m_mtime & 64'hFFFF_FFFF_0000_0000) | 64'(wdata);
        else if (whit && widx == 1) nm = (m_mtime & 64'h0000_0000_FFFF_FFFF) | (64'(wdata) << 32);
        else if (inc) begin
            wrapped = (m_mtime == 64'hFFFF_FFFF_FFFF_FFFF);
            nm = m_mtime + 1;
        end
        m_pend = (m_mtime >= m_cmp);
        m_mtime = nm;
        if (whit && widx == 2) m_cmp = (m_cmp & 64'hFFFF_FFFF_0000_0000) | 64'(wdata);
        if (whit && widx == 3) m_cmp = (m_cmp & 64'h0000_0000_FFFF_FFFF) | (64'(wdata) << 32);
        if (wrapped) m_wrap = 1;
        else if (whit && widx == 6 && wdata[1]) m_wrap = 0;
        if ((whit && (widx == 4 || widx == 5)) || inc) m_pc = 0;
        else if (m_ctrl[0]) m_pc = m_pc + 1;
        if (whit && widx == 4) m_ctrl = wdata[1:0];
        if (whit && widx == 5) m_ps = wdata & 32'h0000_FFFF;
    endtask

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("model_rdata", rdata, m_rdata);
        chk("model_irq", irq, m_pend & m_ctrl[1]);
        chk("model_tick", tick, m_tick);
    endtask

    task automatic idle();
        we = 0; ren = 0; wadr = '0; radr = '0; wdata = '0;
    endtask

    task automatic op(bit w, logic [13:0] wa, logic [31:0] wd, bit r, logic [13:0] ra);
        we = w; wadr = wa; wdata = wd; ren = r; radr = ra;
        cycle();
        idle();
    endtask

    task automatic do_reset();
        rst = 1; idle();
        cycle();
        cycle();
        rst = 0;
    endtask

    typedef struct {
        bit          w;
        logic [13:0] wa;
        logic [31:0] wd;
        bit          r;
        logic [13:0] ra;
        logic [31:0] exp;
    } vec_t;

    function automatic vec_t mkv(bit w, logic [13:0] wa, logic [31:0] wd, bit r, logic [13:0] ra,
                                 logic [31:0] exp);
        vec_t v;
        v.w = w; v.wa = wa; v.wd = wd; v.r = r; v.ra = ra; v.exp = exp;
        return v;
    endfunction

    initial begin
        vec_t tbl[16];
        int   ticks;
        logic [31:0] hi_exp;

        tbl[0]  = mkv(0, 14'h0000, 32'h0,         1, 14'h0080, 32'h0);
        tbl[1]  = mkv(1, 14'h0082, 32'hDEADBEEF,  0, 14'h0000, 32'h0);
        tbl[2]  = mkv(0, 14'h0000, 32'h0,         1, 14'h0082, 32'hDEADBEEF);
        tbl[3]  = mkv(1, 14'h0084, 32'hFFFFFFFC,  1, 14'h0084, 32'h0);
        tbl[4]  = mkv(0, 14'h0000, 32'h0,         1, 14'h0084, 32'h0);
        tbl[5]  = mkv(1, 14'h0085, 32'hABCD1234,  1, 14'h0085, 32'h0);
        tbl[6]  = mkv(0, 14'h0000, 32'h0,         1, 14'h0085, 32'h0000_1234);
        tbl[7]  = mkv(1, 14'h0087, 32'hFFFFFFFF,  1, 14'h0087, 32'h0);
        tbl[8]  = mkv(1, 14'h0182, 32'h5,         1, 14'h0082, 32'hDEADBEEF);
        tbl[9]  = mkv(0, 14'h0000, 32'h0,         1, 14'h0100, 32'h0);
        tbl[10] = mkv(1, 14'h0083, 32'h1,         1, 14'h0086, 32'h0);
        tbl[11] = mkv(1, 14'h0081, 32'h2,         1, 14'h0083, 32'h1);
        tbl[12] = mkv(0, 14'h0000, 32'h0,         1, 14'h0080, 32'h0);
        tbl[13] = mkv(0, 14'h0000, 32'h0,         1, 14'h0081, 32'h2);
        tbl[14] = mkv(0, 14'h0000, 32'h0,         1, 14'h0086, 32'h1);
        tbl[15] = mkv(0, 14'h0000, 32'h0,         0, 14'h0000, 32'h0);

        rst = 1; idle();
        do_reset();
        chk("reset_rdata", rdata, 0);
        chk("reset_irq", irq, 0);
        chk("reset_tick", tick, 0);

        foreach (tbl[i]) begin
            op(tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].r, tbl[i].ra);
            chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp);
            chk($sformatf("tbl%0d_irq", i), irq, 0);
        end

        // Prescale 3: one increment every 4 cycles.
        do_reset();
        op(1, a(5), 32'd3, 0, '0);
        op(1, a(4), 32'd1, 0, '0);
        ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (tick) begin
                chk("tick_spacing", k, 3 + 4 * ticks);
                ticks++;
            end
        end
        chk("tick_count", ticks, 5);
        op(0, '0, '0, 1, a(0));
        chk("ps3_mtime_lo", rdata, 5);

        // Compare match and irq timing.
        do_reset();
        op(1, a(5), 32'd0, 0, '0);
        op(1, a(2), 32'd10, 0, '0);
        op(1, a(3), 32'd0, 0, '0);
        op(1, a(4), 32'd3, 0, '0);
        for (int k = 1; k <= 11; k++) begin
            cycle();
            if (k == 10) chk("irq_before_match", irq, 0);
            if (k == 11) chk("irq_after_match", irq, 1);
        end
        op(1, a(2), 32'd100, 0, '0);
        chk("irq_cmp_write_lag", irq, 1);
        cycle();
        chk("irq_cmp_write_drop", irq, 0);

        // 64-bit wrap and sticky W1C.
        do_reset();
        op(1, a(2), 32'hFFFF_FFFF, 0, '0);
        op(1, a(3), 32'hFFFF_FFFF, 0, '0);
        op(1, a(1), 32'hFFFF_FFFF, 0, '0);
        op(1, a(0), 32'hFFFF_FFFE, 0, '0);
        op(1, a(4), 32'd1, 0, '0);
        cycle();
        op(1, a(4), 32'd0, 0, '0);
        op(0, '0, '0, 1, a(0));
        chk("wrap_mtime_lo", rdata, 0);
        op(0, '0, '0, 1, a(1));
        chk("wrap_mtime_hi", rdata, 0);
        op(0, '0, '0, 1, a(6));
        chk("wrap_status", rdata, 2);
        op(1, a(6), 32'd2, 0, '0);
        op(0, '0, '0, 1, a(6));
        chk("w1c_status", rdata, 0);

        // Miss then hit then idle.
        op(1, a(4), 32'd2, 0, '0);
        op(0, '0, '0, 1, 14'h0100);
        chk("miss_rdata", rdata, 0);
        op(0, '0, '0, 1, a(4));
        chk("hit_ctrl", rdata, 2);
        cycle();
        chk("after_hit", rdata, 0);

        // Coherent read pair across a carry into the high word.
        do_reset();
        op(1, a(1), 32'h1, 0, '0);
        op(1, a(0), 32'hFFFF_FFFF, 0, '0);
        op(1, a(4), 32'd1, 1, a(0));
        chk("pair_lo", rdata, 32'hFFFF_FFFF);
        op(1, a(4), 32'd0, 0, '0);
        op(0, '0, '0, 1, a(1));
`ifdef IO_TIMER_SHADOW_EN
        hi_exp = 32'd1;
`else
        hi_exp = 32'd2;
`endif
        chk("pair_hi", rdata, hi_exp);

        // Random traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int unsigned widx, ridx;
            widx = $urandom_range(0, 7);
            ridx = $urandom_range(0, 7);
            we   = ($urandom_range(0, 2) == 0);
            wadr = ($urandom_range(0, 15) == 0) ? {11'h030, 3'(widx)} : a(widx);
            case (widx)
                0: wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom;
                1: wdata = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom_range(0, 3);
                2: wdata = 32'(m_mtime) + $urandom_range(0, 16);
                3: wdata = 32'(m_mtime >> 32) + $urandom_range(0, 1);
                5: wdata = $urandom & 32'hFFFF_0003;
                default: wdata = $urandom;
            endcase
            ren  = ($urandom_range(0, 1) == 0);
            radr = ($urandom_range(0, 15) == 0) ? {11'h030, 3'(ridx)} : a(ridx);
            cycle();
        end
        idle();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
